slip_decode_strobe: RTL and testbench

//  Registered select generator downstream of the wide-NAND address decode.

---
 rtl/slip_decode_strobe.sv | 83 ++++++++
 tb/tb_slip_decode_strobe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/slip_decode_strobe.sv
// slip_decode_strobe: registered, wait-stretched chip select qualified by a wide AND decode
module slip_decode_strobe #(
    parameter int NTERMS = 7,
    parameter int WAIT_W = 3
) (
    input  logic              MasterClock,
    input  logic              ResetL,
    input  logic [NTERMS-1:0] Term,
    input  logic              Strobe,
    input  logic [WAIT_W-1:0] WaitCount,
    input  logic              ClrOvr,
    output logic              SelL,
    output logic              ReadyL,
    output logic              Busy,
    output logic              Aborted,
    output logic              Overrun
);
    typedef enum logic [1:0] {IDLE, ASSERT, READY, RECOVER} stateT;

    localparam logic [WAIT_W-1:0] ONE = 1;

    stateT             state;
    logic [WAIT_W-1:0] cnt;
    logic              strobeQ;
    logic              match;
    logic              start;

    assign match = &Term;
    assign start = Strobe & ~strobeQ & match;

    // Cycle FSM: select, ready and busy are all registered; the decode is only looked at on Start
    always_ff @(posedge MasterClock or negedge ResetL) begin
        if (!ResetL) begin
            state   <= IDLE;
            cnt     <= '0;
            strobeQ <= 1'b0;
            SelL    <= 1'b1;
            ReadyL  <= 1'b1;
            Busy    <= 1'b0;
            Aborted <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            strobeQ <= Strobe;
            Aborted <= 1'b0;
            if (start && state != IDLE)
                Overrun <= 1'b1;
            else if (ClrOvr)
                Overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ASSERT;
                        cnt   <= WaitCount;
                        SelL  <= 1'b0;
                        Busy  <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (!Strobe) begin
                        state   <= RECOVER;
                        SelL    <= 1'b1;
                        Aborted <= 1'b1;
                    end else if (cnt == '0) begin
                        state  <= READY;
                        ReadyL <= 1'b0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                READY: begin
                    state  <= RECOVER;
                    SelL   <= 1'b1;
                    ReadyL <= 1'b1;
                end
                RECOVER: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slip_decode_strobe.sv
// tb_slip_decode_strobe: directed checks of select timing, abort, overrun and async reset
module tb_slip_decode_strobe;
    logic       MasterClock = 1'b0;
    logic       ResetL;
    logic [6:0] Term;
    logic       Strobe;
    logic [2:0] WaitCount;
    logic       ClrOvr;
    logic       SelL, ReadyL, Busy, Aborted, Overrun;
    int         tests = 0;
    int         failures = 0;

    slip_decode_strobe #(.NTERMS(7), .WAIT_W(3)) dut (
        .MasterClock(MasterClock),
        .ResetL(ResetL),
        .Term(Term),
        .Strobe(Strobe),
        .WaitCount(WaitCount),
        .ClrOvr(ClrOvr),
        .SelL(SelL),
        .ReadyL(ReadyL),
        .Busy(Busy),
        .Aborted(Aborted),
        .Overrun(Overrun)
    );

    always #5 MasterClock = ~MasterClock;

    task automatic tick();
        @(posedge MasterClock);
        #1;
    endtask

    // observed vector is {SelL, ReadyL, Busy, Aborted, Overrun}
    task automatic test_reset();
        repeat (2) @(posedge MasterClock);
        #1;
        tests++;
        if ({SelL, ReadyL, Busy, Aborted, Overrun} !== 5'b11000) begin
            failures++;
            $display("FAIL reset got %b exp %b", {SelL, ReadyL, Busy, Aborted, Overrun}, 5'b11000);
        end
        ResetL = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [4:0] ex;
        WaitCount = 3'd0;
        Strobe = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            ex = {e >= 3 ? 1'b1 : 1'b0, e == 2 ? 1'b0 : 1'b1, e <= 3 ? 1'b1 : 1'b0, 2'b00};
            tests++;
            if ({SelL, ReadyL, Busy, Aborted, Overrun} !== ex) begin
                failures++;
                $display("FAIL basic e%0d got %b exp %b", e, {SelL, ReadyL, Busy, Aborted, Overrun}, ex);
            end
        end
        Strobe = 1'b0;
        tick();
    endtask

    task automatic test_wait5();
        logic [4:0] ex;
        WaitCount = 3'd5;
        Strobe = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            ex = {e <= 7 ? 1'b0 : 1'b1, e == 7 ? 1'b0 : 1'b1, e <= 8 ? 1'b1 : 1'b0, 2'b00};
            tests++;
            if ({SelL, ReadyL, Busy, Aborted, Overrun} !== ex) begin
                failures++;
                $display("FAIL wait5 e%0d got %b exp %b", e, {SelL, ReadyL, Busy, Aborted, Overrun}, ex);
            end
            if (e == 2) begin
                WaitCount = 3'd0;
                Term = 7'b0000000;
            end
        end
        Term = 7'b1111111;
        Strobe = 1'b0;
        tick();
    endtask

    task automatic test_nomatch();
        Term = 7'b1111110;
        Strobe = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            tests++;
            if ({SelL, ReadyL, Busy, Aborted, Overrun} !== 5'b11000) begin
                failures++;
                $display("FAIL nomatch e%0d got %b exp %b", e, {SelL, ReadyL, Busy, Aborted, Overrun}, 5'b11000);
            end
        end
        Strobe = 1'b0;
        tick();
        Term = 7'b1111111;
    endtask

    task automatic test_abort();
        logic [4:0] ex;
        WaitCount = 3'd4;
        Strobe = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            ex = {e <= 3 ? 1'b0 : 1'b1, 1'b1, e <= 4 ? 1'b1 : 1'b0, e == 4 ? 1'b1 : 1'b0, 1'b0};
            tests++;
            if ({SelL, ReadyL, Busy, Aborted, Overrun} !== ex) begin
                failures++;
                $display("FAIL abort e%0d got %b exp %b", e, {SelL, ReadyL, Busy, Aborted, Overrun}, ex);
            end
            if (e == 3) Strobe = 1'b0;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] ex;
        WaitCount = 3'd1;
        Strobe = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            ex = {(e <= 3 || (e >= 6 && e <= 8)) ? 1'b0 : 1'b1,
                  (e == 3 || e == 8) ? 1'b0 : 1'b1,
                  (e == 5 || e == 10) ? 1'b0 : 1'b1, 2'b00};
            tests++;
            if ({SelL, ReadyL, Busy, Aborted, Overrun} !== ex) begin
                failures++;
                $display("FAIL b2b e%0d got %b exp %b", e, {SelL, ReadyL, Busy, Aborted, Overrun}, ex);
            end
            if (e == 3 || e == 8) Strobe = 1'b0;
            if (e == 5) Strobe = 1'b1;
        end
        tick();
    endtask

    task automatic test_overrun();
        logic [4:0] ex;
        WaitCount = 3'd3;
        Strobe = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            ex = {(e <= 5 || e == 10 || e == 11) ? 1'b0 : 1'b1,
                  (e == 5 || e == 11) ? 1'b0 : 1'b1,
                  (e <= 6 || (e >= 10 && e <= 12)) ? 1'b1 : 1'b0,
                  1'b0,
                  (e >= 7 && e <= 13) ? 1'b1 : 1'b0};
            tests++;
            if ({SelL, ReadyL, Busy, Aborted, Overrun} !== ex) begin
                failures++;
                $display("FAIL overrun e%0d got %b exp %b", e, {SelL, ReadyL, Busy, Aborted, Overrun}, ex);
            end
            case (e)
                5, 8, 11: Strobe = 1'b0;
                6: Strobe = 1'b1;
                9: begin
                    Strobe = 1'b1;
                    WaitCount = 3'd0;
                end
                12: begin
                    Strobe = 1'b1;
                    ClrOvr = 1'b1;
                end
                default: ;
            endcase
        end
        ClrOvr = 1'b0;
        Strobe = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        WaitCount = 3'd4;
        Strobe = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            tests++;
            if ({SelL, ReadyL, Busy, Aborted, Overrun} !== 5'b01100) begin
                failures++;
                $display("FAIL arst_pre e%0d got %b exp %b", e, {SelL, ReadyL, Busy, Aborted, Overrun}, 5'b01100);
            end
        end
        #2 ResetL = 1'b0;
        #1;
        tests++;
        if ({SelL, ReadyL, Busy, Aborted, Overrun} !== 5'b11000) begin
            failures++;
            $display("FAIL arst_immediate got %b exp %b", {SelL, ReadyL, Busy, Aborted, Overrun}, 5'b11000);
        end
        tick();
        tests++;
        if ({SelL, ReadyL, Busy, Aborted, Overrun} !== 5'b11000) begin
            failures++;
            $display("FAIL arst_held got %b exp %b", {SelL, ReadyL, Busy, Aborted, Overrun}, 5'b11000);
        end
        ResetL = 1'b1;
        tick();
        tests++;
        if ({SelL, ReadyL, Busy, Aborted, Overrun} !== 5'b01100) begin
            failures++;
            $display("FAIL arst_restart got %b exp %b", {SelL, ReadyL, Busy, Aborted, Overrun}, 5'b01100);
        end
        Strobe = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        ResetL = 1'b0;
        Term = 7'b1111111;
        Strobe = 1'b0;
        WaitCount = 3'd0;
        ClrOvr = 1'b0;
        test_reset();
        test_basic();
        test_wait5();
        test_nomatch();
        test_abort();
        test_back_to_back();
        test_overrun();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
